// File: rtl/y86_pkg.sv
// Y86-64 encoding constants shared by fetch and the instruction encoder.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Highest legal function code for ALU ops and for condition codes.
  localparam logic [3:0] OPQ_IFUN_MAX  = 4'd3;
  localparam logic [3:0] COND_IFUN_MAX = 4'd6;

  // Instruction layout classes: opcode only, +register byte,
  // +8-byte constant, or register byte plus constant.
  typedef enum logic [1:0] {FMT_BYTE, FMT_REGS, FMT_DEST, FMT_FULL} fmt_e;

  typedef enum logic {ST_IDLE, ST_EMIT} state_e;

  function automatic fmt_e icode_fmt(input logic [3:0] icode);
    case (icode)
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: return FMT_REGS;
      I_JXX, I_CALL:                    return FMT_DEST;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     return FMT_FULL;
      default:                          return FMT_BYTE;
    endcase
  endfunction

  function automatic logic [3:0] fmt_length(input fmt_e fmt);
    case (fmt)
      FMT_REGS: return 4'd2;
      FMT_DEST: return 4'd9;
      FMT_FULL: return 4'd10;
      default:  return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/instr_len.sv
// Combinational decode of an instruction's byte length, layout and legality.
module instr_len
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic [3:0] ifun,
  output logic [3:0] length,
  output logic       has_regs,
  output logic       has_valC,
  output logic       legal
);

  fmt_e fmt;

  // Layout class drives length and which optional fields are present.
  // NOTE: every output is given a value before any branch so no latch is inferred.
  always_comb begin
    fmt      = icode_fmt(icode);
    length   = fmt_length(fmt);
    has_regs = (fmt == FMT_REGS) || (fmt == FMT_FULL);
    has_valC = (fmt == FMT_DEST) || (fmt == FMT_FULL);
    legal    = 1'b0;
    case (icode)
      I_OPQ:          legal = (ifun <= OPQ_IFUN_MAX);
      I_RRMOVQ, I_JXX: legal = (ifun <= COND_IFUN_MAX);
      I_HALT, I_NOP, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
      I_CALL, I_RET, I_PUSHQ, I_POPQ:
                      legal = (ifun == 4'h0);
      default:        legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Serialises Y86-64 instruction fields into the byte stream fetch decodes,
// one byte-write per cycle into instruction memory.
module instr_encoder
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] valC,
  input  logic        addr_load,
  input  logic [63:0] addr_val,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_data,
  input  logic        mem_ready,
  output logic [63:0] next_addr,
  output logic        instr_error,
  output logic [15:0] instr_count
);

  state_e      state, state_nx;
  logic [3:0]  len_in;
  logic        regs_in, valc_in, legal_in;
  logic [3:0]  icode_q, ifun_q, ra_q, rb_q, len_q, idx;
  logic [63:0] valc_q, wr_addr;
  logic        has_regs_q, has_valc_q;
  logic        accept, last_byte;
  logic [2:0]  voff;

  instr_len u_instr_len (
    .icode    (icode),
    .ifun     (ifun),
    .length   (len_in),
    .has_regs (regs_in),
    .has_valC (valc_in),
    .legal    (legal_in)
  );

  assign accept    = in_valid && (state == ST_IDLE);
  assign last_byte = (state == ST_EMIT) && mem_ready && (idx == len_q - 4'd1);

  // State register.
  // NOTE: clocked state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next state: leave IDLE on a legal acceptance, return once the last byte lands.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept && legal_in) state_nx = ST_EMIT;
      ST_EMIT: if (last_byte)          state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Captured fields, byte index, write address and status counters.
  // Payload registers are reset too so mem_data reads 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icode_q     <= '0;
      ifun_q      <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      valc_q      <= '0;
      len_q       <= '0;
      has_regs_q  <= 1'b0;
      has_valc_q  <= 1'b0;
      idx         <= '0;
      wr_addr     <= '0;
      next_addr   <= '0;
      instr_error <= 1'b0;
      instr_count <= '0;
    end else begin
      instr_error <= accept && !legal_in;
      if (state == ST_IDLE) begin
        // Loading in the same cycle as acceptance places the instruction at addr_val.
        if (addr_load) begin
          wr_addr   <= addr_val;
          next_addr <= addr_val;
        end
        if (accept && legal_in) begin
          icode_q    <= icode;
          ifun_q     <= ifun;
          ra_q       <= rA;
          rb_q       <= rB;
          valc_q     <= valC;
          len_q      <= len_in;
          has_regs_q <= regs_in;
          has_valc_q <= valc_in;
          idx        <= '0;
        end
      end else if (mem_ready) begin
        if (last_byte) begin
          wr_addr     <= wr_addr + {60'd0, len_q};
          next_addr   <= wr_addr + {60'd0, len_q};
          instr_count <= instr_count + 16'd1;
          idx         <= '0;
        end else begin
          idx <= idx + 4'd1;
        end
      end
    end
  end

  assign in_ready = (state == ST_IDLE);
  assign mem_we   = (state == ST_EMIT);
  assign mem_addr = wr_addr + {60'd0, idx};

  // Byte select from registered fields only: opcode, register pair, then valC LSB first.
  always_comb begin
    voff     = 3'(idx - (has_regs_q ? 4'd2 : 4'd1));
    mem_data = {icode_q, ifun_q};
    if (idx != 4'd0) begin
      if (has_regs_q && idx == 4'd1) mem_data = {ra_q, rb_q};
      else if (has_valc_q)           mem_data = valc_q[{voff, 3'b000} +: 8];
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a byte-stream model built from the
// Y86-64 layout rules plus literal byte expectations for known instructions.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC;
  logic        addr_load;
  logic [63:0] addr_val;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ready;
  logic [63:0] next_addr;
  logic        instr_error;
  logic [15:0] instr_count;

  instr_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC),
    .addr_load(addr_load), .addr_val(addr_val),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ready(mem_ready), .next_addr(next_addr),
    .instr_error(instr_error), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  log_q[$];
  logic [63:0] m_addr;
  logic [15:0] m_count;
  int          checks   = 0;
  int          failures = 0;
  int          cycles;
  int          n0;
  logic [7:0]  lit[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic int spec_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       return 1;
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h7, 4'h8:             return 9;
      4'h3, 4'h4, 4'h5:       return 10;
      default:                return 0;
    endcase
  endfunction

  function automatic bit spec_legal(input logic [3:0] ic, input logic [3:0] fn);
    if (ic > 4'hB) return 1'b0;
    if (ic == 4'h6) return fn <= 4'd3;
    if (ic == 4'h2 || ic == 4'h7) return fn <= 4'd6;
    return fn == 4'h0;
  endfunction

  // Expected byte stream from the layout rules.
  task automatic model_push(input logic [3:0] ic, fn, ra, rb, input logic [63:0] vc,
                            input logic [63:0] base);
    logic [7:0] bytes[$];
    int n = spec_len(ic);
    bytes.push_back({ic, fn});
    if (n == 2 || n == 10) bytes.push_back({ra, rb});
    if (n >= 9) for (int k = 0; k < 8; k++) bytes.push_back(vc[8*k +: 8]);
    for (int i = 0; i < bytes.size(); i++) begin
      wr_t w;
      w.addr = base + 64'(i);
      w.data = bytes[i];
      exp_q.push_back(w);
    end
  endtask

  // Every write cycle is compared against the model head; a byte is consumed only when memory accepts it.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", {63'd0, mem_we}, 64'd0);
      end else begin
        check("wr_addr", mem_addr, exp_q[0].addr);
        check("wr_data", {56'd0, mem_data}, {56'd0, exp_q[0].data});
        if (mem_ready) begin
          log_q.push_back(mem_data);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [3:0] ic, fn, ra, rb, input logic [63:0] vc,
                        input bit load, input logic [63:0] la);
    int t = 0;
    while (!in_ready && t < 50) begin step(); t++; end
    check("ready_before_accept", {63'd0, in_ready}, 64'd1);
    icode = ic; ifun = fn; rA = ra; rB = rb; valC = vc;
    in_valid = 1'b1; addr_load = load; addr_val = la;
    if (load) m_addr = la;
    if (spec_legal(ic, fn)) begin
      model_push(ic, fn, ra, rb, vc, m_addr);
      m_addr  = m_addr + 64'(spec_len(ic));
      m_count = m_count + 16'd1;
    end
    step();
    in_valid = 1'b0; addr_load = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (!in_ready && cyc < 100) begin step(); cyc++; end
    check("idle_timeout", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic check_done(input string name);
    check({name, "_bytes_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_next_addr"}, next_addr, m_addr);
    check({name, "_count"}, {48'd0, instr_count}, {48'd0, m_count});
  endtask

  task automatic check_bytes(input string name, input int start, input int n);
    for (int i = 0; i < n; i++)
      check(name, {56'd0, log_q[start+i]}, {56'd0, lit[i]});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; addr_load = 1'b0; addr_val = '0;
    icode = '0; ifun = '0; rA = '0; rB = '0; valC = '0; mem_ready = 1'b1;
    m_addr = '0; m_count = '0;
    #2;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_mem_we", {63'd0, mem_we}, 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_mem_data", {56'd0, mem_data}, 64'd0);
    check("rst_next_addr", next_addr, 64'd0);
    check("rst_instr_error", {63'd0, instr_error}, 64'd0);
    check("rst_instr_count", {48'd0, instr_count}, 64'd0);
    step();
    rst = 1'b0;

    // irmovq $0x100, %rax at address 0
    n0 = log_q.size();
    accept(4'h3, 4'h0, 4'hF, 4'h0, 64'h100, 1'b0, '0);
    wait_idle(cycles);
    check("irmovq_cycles", 64'(cycles), 64'd10);
    lit = '{8'h30, 8'hF0, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_bytes("irmovq_lit", n0, 10);
    check("irmovq_next_lit", next_addr, 64'd10);
    check("irmovq_count_lit", {48'd0, instr_count}, 64'd1);
    check_done("irmovq");

    // halt directly after: one byte at 10
    n0 = log_q.size();
    accept(4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0, '0);
    wait_idle(cycles);
    check("halt_cycles", 64'(cycles), 64'd1);
    check("halt_byte_lit", {56'd0, log_q[n0]}, 64'h00);
    check("halt_next_lit", next_addr, 64'd11);
    check_done("halt");

    // addq %rdx,%rbx; an addr_load during EMIT must be ignored
    n0 = log_q.size();
    accept(4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 1'b0, '0);
    addr_load = 1'b1; addr_val = 64'h999;
    step();
    addr_load = 1'b0;
    wait_idle(cycles);
    lit = '{8'h60, 8'h23, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
    check_bytes("addq_lit", n0, 2);
    check("addq_next_lit", next_addr, 64'd13);
    check_done("addq");

    // addr_load in IDLE, then call 0x20
    addr_load = 1'b1; addr_val = 64'h40; m_addr = 64'h40;
    step();
    addr_load = 1'b0;
    check("load_next_addr", next_addr, 64'h40);
    n0 = log_q.size();
    accept(4'h8, 4'h0, 4'h0, 4'h0, 64'h20, 1'b0, '0);
    wait_idle(cycles);
    check("call_cycles", 64'(cycles), 64'd9);
    lit = '{8'h80, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0};
    check_bytes("call_lit", n0, 9);
    check("call_next_lit", next_addr, 64'h49);
    check_done("call");

    // Illegal instructions: one-cycle error pulse, no writes, address unchanged
    for (int i = 0; i < 2; i++) begin
      if (i == 0) accept(4'hC, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0, '0);
      else        accept(4'h6, 4'h4, 4'h1, 4'h2, 64'h0, 1'b0, '0);
      check("illegal_error_hi", {63'd0, instr_error}, 64'd1);
      check("illegal_in_ready", {63'd0, in_ready}, 64'd1);
      check("illegal_mem_we", {63'd0, mem_we}, 64'd0);
      step();
      check("illegal_error_lo", {63'd0, instr_error}, 64'd0);
      check("illegal_next_lit", next_addr, 64'h49);
      check_done("illegal");
    end

    // rrmovq %rcx,%rdx loaded at 0 in the acceptance cycle; stall on byte 1
    n0 = log_q.size();
    accept(4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 1'b1, 64'h0);
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_we", {63'd0, mem_we}, 64'd1);
      check("stall_addr", mem_addr, 64'd1);
      check("stall_data", {56'd0, mem_data}, 64'h12);
      step();
    end
    mem_ready = 1'b1;
    wait_idle(cycles);
    check("stall_written", 64'(log_q.size() - n0), 64'd2);
    lit = '{8'h20, 8'h12, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
    check_bytes("stall_lit", n0, 2);
    check_done("stall");

    // Address wrap-around across 2^64
    accept(4'h3, 4'h0, 4'hF, 4'h7, 64'h1122_3344_5566_7788, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_idle(cycles);
    check("wrap_next_lit", next_addr, 64'd9);
    check_done("wrap");

    // Reset while emitting byte 4 of mrmovq
    n0 = log_q.size();
    accept(4'h5, 4'h0, 4'h1, 4'h2, 64'hABCD, 1'b0, '0);
    for (int i = 0; i < 4; i++) step();
    check("abort_written", 64'(log_q.size() - n0), 64'd4);
    check("abort_we_before", {63'd0, mem_we}, 64'd1);
    rst = 1'b1;
    #1;
    check("abort_mem_we", {63'd0, mem_we}, 64'd0);
    exp_q.delete();
    m_addr = '0; m_count = '0;
    step();
    rst = 1'b0;
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    check("abort_next_addr", next_addr, 64'd0);
    check("abort_count", {48'd0, instr_count}, 64'd0);

    // Normal operation resumes at address 0
    accept(4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0, '0);
    wait_idle(cycles);
    check("post_rst_next_lit", next_addr, 64'd1);
    check_done("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: in_valid  in  1  instruction fields presented.
REQ-004 SHALL have: in_ready  out  1  encoder can accept an instruction.
REQ-005 SHALL have: icode  in  4; ifun  in  4; rA  in  4; rB  in  4; valC  in  64  (Y86-64 instruction fields).
REQ-006 SHALL have: addr_load  in  1; addr_val  in  64  (set write address).
REQ-007 SHALL have: mem_we  out  1; mem_addr  out  64; mem_data  out  8  (byte write to instruction memory).
REQ-008 SHALL have: mem_ready  in  1  memory accepts the current byte this cycle.
REQ-009 SHALL have: next_addr  out  64  (address after the last byte written, i.e. valP of the last instruction).
REQ-010 SHALL have: instr_error  out  1  (one-cycle pulse on an illegal instruction); instr_count  out  16  (instructions fully written).

Function
REQ-011 SHALL be the inverse of fetch: serialize fields into the exact byte stream that fetch decodes.
REQ-012 Byte 0 SHALL be {icode,ifun}; byte 1, when present, {rA,rB}; valC SHALL follow little-endian, LSB first.
REQ-013 Lengths SHALL be: halt(0), nop(1), ret(9) = 1; rrmovq/cmovXX(2), OPq(6), pushq(A), popq(B) = 2; jXX(7), call(8) = 9 (no register byte); irmovq(3), rmmovq(4), mrmovq(5) = 10.
REQ-014 Illegal SHALL mean icode > 0xB, OPq with ifun > 3, cmovXX/jXX with ifun > 6, or any other icode with ifun != 0.
REQ-015 The FSM SHALL have states IDLE and EMIT; in_ready = 1 exactly in IDLE.
REQ-016 On in_valid & in_ready with a legal instruction, fields SHALL be registered, and the FSM SHALL enter EMIT with byte index 0.
REQ-017 In EMIT, mem_we SHALL be 1, mem_addr = wr_addr + index, and mem_data = the selected byte; the first write SHALL appear the cycle after acceptance.
REQ-018 The byte index SHALL advance only when mem_ready = 1; mem_addr and mem_data SHALL be held stable while mem_ready = 0.
REQ-019 When the last byte is accepted: wr_addr += length, next_addr = new wr_addr, instr_count += 1 (wraps 0xFFFF -> 0), and the FSM SHALL return to IDLE.
REQ-020 With mem_ready held at 1, throughput SHALL be one byte per cycle plus one IDLE cycle between instructions.
REQ-021 On an accepted illegal instruction: no write, wr_addr unchanged, FSM stays IDLE, instr_error = 1 for the following cycle only.
REQ-022 addr_load in IDLE SHALL set wr_addr and next_addr to addr_val next cycle; addr_load in EMIT SHALL be ignored.
REQ-023 When addr_load and an acceptance occur in the same IDLE cycle, the instruction SHALL be written starting at addr_val.
REQ-024 Address arithmetic SHALL be 64-bit modulo 2^64 (wrap-around allowed, no flag).
REQ-025 All outputs SHALL be registered or decoded only from registered state; no combinational path from in_* to mem_*.

Reset
REQ-026 On rst, asynchronously: FSM = IDLE, in_ready = 1, mem_we = 0, mem_addr = 0, mem_data = 0, wr_addr = 0, next_addr = 0, instr_error = 0, instr_count = 0.
REQ-027 rst during EMIT SHALL abort the instruction; partially written bytes are not rolled back, and instr_count is not incremented.

Structure
REQ-028 The y86_pkg package SHALL hold the icode constants, ifun limits, and the length encoding shared with fetch.
REQ-029 One combinational sub-module, instr_len (icode, ifun -> length[3:0], has_regs, has_valC, legal), SHALL be instantiated once.

Verification
REQ-030 irmovq icode=3 ifun=0 rA=F rB=0 valC=0x100 at addr 0 -> bytes 30 F0 00 01 00 00 00 00 00 00 written at addr 0..9; next_addr = 10; instr_count = 1.
REQ-031 Then halt (0,0) -> single byte 00 at addr 10; next_addr = 11; then addq rA=2 rB=3 -> 60 23 at addr 11..12.
REQ-032 call valC=0x20 after addr_load 0x40 -> bytes 80 20 00 00 00 00 00 00 00 at addr 0x40..0x48; next_addr = 0x49.
REQ-033 icode=0xC (and OPq ifun=4) -> instr_error pulses exactly 1 cycle; mem_we never asserted; next_addr unchanged.
REQ-034 mem_ready = 0 for 3 cycles at byte 1 of rrmovq 20 12 -> mem_addr and mem_data held at 1 / 0x12 for those cycles; total 2 bytes written exactly once each.
REQ-035 rst asserted at byte 4 of mrmovq -> mem_we = 0 immediately; after release, in_ready = 1, next_addr = 0, instr_count = 0.
